// File: rtl/warp_issue_seq.sv
// ---------------------------------------------------------------------------
// warp_issue_seq
//
// Buffers decoded warp instructions (each with a full-warp active-thread
// mask) in a small FIFO and issues them to the dispatch stage one lane
// group per cycle. Groups with no active threads are skipped. Idle cycles
// present a NOP with an all-zero thread mask so downstream quiesces.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   inst_valid_i      upstream instruction valid
//   inst_ready_o      buffer can accept (from registered count only)
//   inst_i            instruction word
//   warp_id_i         warp ID
//   warp_mask_i       active-thread mask of the warp
//   stall_i           downstream stall: hold sequencer, present idle
//   Inst_o            instruction to dispatch (NOP when idle)
//   WarpID_o          warp ID to dispatch
//   thread_mask_o     active lanes of the issued group
//   group_o           index of the issued lane group
//   issue_valid_o     an issue is present this cycle
//   last_o            final group of the current instruction
//   busy_o            FIFO non-empty or sequencing in progress
// ---------------------------------------------------------------------------
module warp_issue_seq #(
    parameter int LANES        = 4,
    parameter int WARP_THREADS = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int INST_W       = 32,
    parameter int WID_W        = 6,
    localparam int GROUPS      = WARP_THREADS / LANES,
    localparam int GROUP_W     = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inst_valid_i,
    output logic                    inst_ready_o,
    input  logic [INST_W-1:0]       inst_i,
    input  logic [WID_W-1:0]        warp_id_i,
    input  logic [WARP_THREADS-1:0] warp_mask_i,
    input  logic                    stall_i,
    output logic [INST_W-1:0]       Inst_o,
    output logic [WID_W-1:0]        WarpID_o,
    output logic [LANES-1:0]        thread_mask_o,
    output logic [GROUP_W-1:0]      group_o,
    output logic                    issue_valid_o,
    output logic                    last_o,
    output logic                    busy_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                  state_q, state_d;
    logic [WARP_THREADS-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;

    logic [INST_W-1:0]       inst_q, inst_d;
    logic [WID_W-1:0]        wid_q, wid_d;
    logic [LANES-1:0]        tmask_q, tmask_d;
    logic [GROUP_W-1:0]      group_q, group_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    busy_q, busy_d;

    // Instruction buffer storage
    logic [INST_W-1:0]       inst_mem [FIFO_DEPTH];
    logic [WID_W-1:0]        wid_mem  [FIFO_DEPTH];
    logic [WARP_THREADS-1:0] mask_mem [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Push side
    // ------------------------------------------------------------------
    logic push_fire;
    logic push_store;
    logic pop;

    assign inst_ready_o = (count_q < CNT_W'(FIFO_DEPTH));
    assign push_fire    = inst_valid_i & inst_ready_o;
    // An all-zero mask completes the handshake but has nothing to issue.
    assign push_store   = push_fire & (|warp_mask_i);

    always_ff @(posedge clk) begin
        if (push_store) begin
            inst_mem[wr_ptr_q] <= inst_i;
            wid_mem[wr_ptr_q]  <= warp_id_i;
            mask_mem[wr_ptr_q] <= warp_mask_i;
        end
    end

    // ------------------------------------------------------------------
    // Working mask and group selection
    // ------------------------------------------------------------------
    logic [INST_W-1:0]       head_inst;
    logic [WID_W-1:0]        head_wid;
    logic [WARP_THREADS-1:0] head_mask;
    logic [WARP_THREADS-1:0] working;
    logic [WARP_THREADS-1:0] remainder;
    logic [GROUPS-1:0]       grp_nz;
    logic [LANES-1:0]        grp_lanes [GROUPS];
    logic [GROUP_W-1:0]      sel_g;

    // The entry being sequenced stays at the FIFO head until its last
    // group issues, so the head always supplies Inst/WarpID.
    assign head_inst = inst_mem[rd_ptr_q];
    assign head_wid  = wid_mem[rd_ptr_q];
    assign head_mask = mask_mem[rd_ptr_q];

    always_comb begin
        working = '0;
        if (state_q == ST_ISSUE) begin
            working = rem_q;
        end else if (count_q != '0) begin
            working = head_mask;
        end
    end

    generate
        for (genvar gi = 0; gi < GROUPS; gi++) begin : g_groups
            assign grp_lanes[gi] = working[gi*LANES +: LANES];
            assign grp_nz[gi]    = |working[gi*LANES +: LANES];
        end
    endgenerate

    // Lowest non-empty group wins: scan downward so the last hit is lowest.
    always_comb begin
        sel_g = '0;
        for (int i = GROUPS - 1; i >= 0; i--) begin
            if (grp_nz[i]) begin
                sel_g = GROUP_W'(i);
            end
        end
    end

    always_comb begin
        remainder = working;
        for (int i = 0; i < GROUPS; i++) begin
            if (GROUP_W'(i) == sel_g) begin
                remainder[i*LANES +: LANES] = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        pop      = 1'b0;
        inst_d   = NOP_INST;
        wid_d    = '0;
        tmask_d  = '0;
        group_d  = '0;
        valid_d  = 1'b0;
        last_d   = 1'b0;

        // A stall freezes the sequencer; outputs fall back to idle.
        if (!stall_i && (working != '0)) begin
            inst_d  = head_inst;
            wid_d   = head_wid;
            tmask_d = grp_lanes[sel_g];
            group_d = sel_g;
            valid_d = 1'b1;
            if (remainder == '0) begin
                last_d  = 1'b1;
                pop     = 1'b1;
                state_d = ST_IDLE;
                rem_d   = '0;
            end else begin
                state_d = ST_ISSUE;
                rem_d   = remainder;
            end
        end

        count_d  = count_q + CNT_W'(push_store) - CNT_W'(pop);
        wr_ptr_d = push_store ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        busy_d   = (count_d != '0) | (state_d == ST_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            inst_q   <= NOP_INST;
            wid_q    <= '0;
            tmask_q  <= '0;
            group_q  <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            inst_q   <= inst_d;
            wid_q    <= wid_d;
            tmask_q  <= tmask_d;
            group_q  <= group_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
        end
    end

    assign Inst_o        = inst_q;
    assign WarpID_o      = wid_q;
    assign thread_mask_o = tmask_q;
    assign group_o       = group_q;
    assign issue_valid_o = valid_q;
    assign last_o        = last_q;
    assign busy_o        = busy_q;

endmodule

// File: doc/warp_issue_seq.md
Name: warp_issue_seq

Overview:
- Sits directly upstream of the instruction dispatch stage and drives its instruction, warp-ID and 4-bit thread-mask inputs.
- Buffers decoded warp instructions, each carrying a full-warp active mask, in a small FIFO.
- Sequences each instruction over the 4-lane datapath: one lane group per cycle, skipping groups with no active threads.
- An idle cycle presents thread mask 0 with a NOP, so downstream zeroes its register addresses and ALU selects.

Parameters:
- LANES, 4, threads issued per cycle; equals downstream thread_mask width.
- WARP_THREADS, 16, threads per warp; must be a multiple of LANES. GROUPS = WARP_THREADS/LANES.
- FIFO_DEPTH, 4, instruction buffer entries; power of two.
- INST_W, 32, instruction width.
- WID_W, 6, warp-ID width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- inst_valid_i  in  1  upstream instruction valid.
- inst_ready_o  out  1  buffer can accept.
- inst_i  in  INST_W  RV32 instruction word.
- warp_id_i  in  WID_W  warp ID.
- warp_mask_i  in  WARP_THREADS  active-thread mask of the warp.
- stall_i  in  1  downstream stall; no progress this cycle.
- Inst_o  out  INST_W  instruction to dispatch.
- WarpID_o  out  WID_W  warp ID to dispatch.
- thread_mask_o  out  LANES  active lanes of the issued group.
- group_o  out  clog2(GROUPS)  index of the issued lane group.
- issue_valid_o  out  1  an issue is present this cycle.
- last_o  out  1  final group of the current instruction.
- busy_o  out  1  FIFO non-empty or group sequencing in progress.

Behaviour:
- Reset (sync, rst=1 at an edge) clears the FIFO (count 0, pointers 0) and the sequencer. All outputs take idle values:
  - Inst_o=32'h00000013, WarpID_o=0, thread_mask_o=0, group_o=0, issue_valid_o=0, last_o=0, busy_o=0.
  - inst_ready_o=1 after reset.
  - Reset mid-sequence discards the remaining groups and all buffered entries.
- inst_ready_o = (count < FIFO_DEPTH), computed from registered count only. A push when full is impossible, even if a pop occurs in the same cycle.
- Push on inst_valid_i & inst_ready_o. If warp_mask_i==0, the handshake completes but nothing is stored (dropped).
- Sequencer state is the register rem (WARP_THREADS bits) plus flag act. States:
  - IDLE: act=0.
  - ISSUE: act=1, rem holds the current entry's not-yet-issued threads.
- The working mask each edge is rem if act, else the FIFO head mask if count>0.
- Each edge with stall_i=0 and a non-zero working mask:
  - g = lowest index with a non-zero group working[g*LANES +: LANES].
  - Registered outputs: Inst_o/WarpID_o from the current entry, thread_mask_o = that group, group_o=g, issue_valid_o=1.
  - Clear group g from the working mask.
  - If the remainder is zero: last_o=1, pop the FIFO head, act<=0. Otherwise last_o=0, act<=1, rem<=remainder.
- No bubble between entries. The cycle after a last_o issue, the next head (if present) issues its first group.
- Latency: an entry pushed into an empty, idle buffer at edge E issues its first group at edge E+1.
- stall_i=1 at an edge:
  - Outputs go to idle values; rem, act and FIFO head are unchanged.
  - Pushes still occur.
  - The sequence resumes at the same group when stall_i drops. No group is lost or duplicated.
- No work and stall_i=0: outputs take idle values.
- A simultaneous push and pop in one cycle keeps count unchanged. Pointers wrap modulo FIFO_DEPTH.
- busy_o (registered) = (count_next != 0) | act_next.

Test Plan:
- Reset then push {inst=32'h00208033, wid=5, mask=16'h00F1}. Expected issues:
  - cycle E+1: thread_mask_o=4'h1, group_o=0, last_o=0.
  - cycle E+2: 4'hF, group_o=1, last_o=1.
  - cycle E+3: idle (mask 0, Inst_o=32'h00000013).
- Push mask 16'h8000 then mask 16'h0101 back-to-back. Expected issues on consecutive cycles with no gap:
  - (g3, 4'h8, last=1)
  - (g0, 4'h1, last=0)
  - (g2, 4'h1, last=1)
- Fill 4 entries of mask 16'hFFFF with stall_i=1. inst_ready_o=0 after the fourth push; a fifth push is not accepted. Release the stall: 16 consecutive issues, last_o on every 4th, inst_ready_o=1 after the first pop.
- Assert stall_i for 3 cycles mid-sequence of mask 16'h0F0F after the group-0 issue. Outputs are idle for those cycles, then group 2 issues with 4'hF, last=1. Group 0 is not repeated.
- Push mask 16'h0000. Handshake completes, no issue occurs, busy_o stays 0.
- Assert rst during the second group of a 16'hFFFF entry with 2 more entries queued. Next cycle all outputs are idle and busy_o=0; a fresh push issues normally.
